maple_tx_engine: RTL and testbench
==================================

MAPLE_TX_ENGINE -- requirements
Module: maple_tx_engine

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of Maple ports driven (min 1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: TX byte FIFO depth (power of two, min 2).
REQ-003 SHALL have parameter DIV_W, default 8: width of the tick divider.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port clk_div  input  DIV_W  tick period minus one, in clk cycles.
REQ-007 SHALL have port port_sel  input  max(1,clog2(NUM_PORTS))  target port, latched on accepted start.
REQ-008 SHALL have port wr_data  input  8  byte to enqueue.
REQ-009 SHALL have port wr_en  input  1  enqueue strobe.
REQ-010 SHALL have port start  input  1  request a frame.
REQ-011 SHALL have port abort  input  1  synchronous frame abort.
REQ-012 SHALL have port full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-013 SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-014 SHALL have port overflow  output  1  sticky: write attempted while full.
REQ-015 SHALL have port busy  output  1  frame in progress.
REQ-016 SHALL have port done  output  1  one-clk pulse on normal frame completion.
REQ-017 SHALL have ports out_p1, out_p5  output  NUM_PORTS each  per-port line drive values (SDCKA, SDCKB).
REQ-018 SHALL have port oe  output  NUM_PORTS  per-port output enable.

Function
REQ-019 Divider: counter counts 0..clk_div, tick=1 for the clk where count==clk_div, then counter reloads 0; clk_div=0 gives tick every clk; runs continuously regardless of state.
REQ-020 FIFO: write accepted iff wr_en && !full (checked on current count, even if a pop occurs that same clk); simultaneous accepted write and pop leaves count unchanged; rejected write sets overflow.
REQ-021 overflow SHALL clear only on reset or accepted start.
REQ-022 Start is accepted iff start && !busy && !empty; otherwise ignored without side effects (no done pulse). Accept latches port_sel, sets busy next clk.
REQ-023 Line/FSM state SHALL advance only on clk edges with tick=1; each listed step lasts one tick.
REQ-024 IDLE: all out_p1=out_p5=1, oe=0.
REQ-025 PRE (1 step): selected port oe=1, p1=1, p5=1.
REQ-026 SYNC (10 steps): p1=0,p5=1; then p5 = 0,1,0,1,0,1,0,1 with p1=0; then p1=1,p5=1.
REQ-027 DATA: byte popped at start of its first bit; bits MSB first; each bit 3 steps: (a) clock line=1, data line=bit; (b) clock line=0; (c) clock line=1. Bits 7,5,3,1 use p1 clock/p5 data; bits 6,4,2,0 use p5 clock/p1 data.
REQ-028 After bit 0, if FIFO non-empty, next byte follows immediately; else END. Bytes written during a frame SHALL be sent if present at byte boundary.
REQ-029 END (7 steps): p1=1,p5=1; p5=0; p1 = 0,1,0,1 with p5=0; p5=1,p1=1. Then IDLE: oe=0, busy=0, done=1 for one clk.
REQ-030 Non-selected ports SHALL hold oe=0, p1=p5=1 always.
REQ-031 abort (any state): next clk oe=0 all ports, FSM IDLE, busy=0, FIFO flushed, no done; abort in IDLE only flushes FIFO.
REQ-032 start and abort same clk: abort wins, start discarded.
REQ-033 port_sel >= NUM_PORTS: start accepted, frame timed normally, no oe asserted.

Reset
REQ-034 While rst=0: FSM IDLE, FIFO empty (empty=1, full=0), overflow=0, busy=0, done=0, oe=0, out_p1=out_p5=all ones, divider count=0; reset mid-frame releases lines immediately.

Verification
REQ-035 clk_div=0, write 0xA5, start, port_sel=2 -> oe[2] high 42 clks (1+10+24+7 steps), p1/p5 follow REQ-025..029 with bits 1,0,1,0,0,1,0,1; done one pulse; other oe stay 0.
REQ-036 clk_div=3, write 0x00,0xFF, start -> each step 4 clks, 66 steps total, FIFO empty at done.
REQ-037 Write FIFO_DEPTH+1 bytes in IDLE -> full=1 after 16th, overflow=1, 17th dropped; subsequent start clears overflow, sends exactly 16 bytes.
REQ-038 Start with FIFO empty; start while busy -> no state change, no extra done.
REQ-039 Abort during DATA bit 3 of second byte -> next clk oe=0, busy=0, empty=1, no done; reset asserted mid-frame -> all outputs at REQ-034 values asynchronously.
REQ-040 Write a byte during last byte's bit 2 -> sent back-to-back, single done after it.

Source files
------------

// File: rtl/maple_tx_engine.sv
// Maple bus transmit engine: byte FIFO feeding a tick-paced frame sequencer
// (start pattern, MSB-first data on alternating clock lines, end pattern).
module maple_tx_engine #(
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 8,
    localparam int PSW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     clk_div,
    input  logic [PSW-1:0]       port_sel,
    input  logic [7:0]           wr_data,
    input  logic                 wr_en,
    input  logic                 start,
    input  logic                 abort,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_PORTS-1:0] out_p1,
    output logic [NUM_PORTS-1:0] out_p5,
    output logic [NUM_PORTS-1:0] oe
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_PRE, S_SYNC, S_DATA, S_END
    } state_t;

    state_t           state, state_n;
    logic [3:0]       step, step_n;
    logic [2:0]       bit_idx, bit_n;
    logic [1:0]       phase, phase_n;
    logic [DIV_W-1:0] div_cnt;
    logic             tick, accept, pop, fin, wr_acc;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [7:0]       shreg;
    logic [PSW-1:0]   sel;
    logic             line_p1, line_p5, clk_line, dat_line, active, hit;

    // Free-running divider; >= guards against clk_div shrinking below the count
    assign tick = (div_cnt >= clk_div);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    assign full   = (count == CW'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign wr_acc = wr_en && !full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
                if (pop)    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(wr_acc) - CW'(pop);
            end
            if (accept)        overflow <= 1'b0;
            if (wr_en && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= wr_data;
        if (pop)    shreg <= mem[rd_ptr];
        if (accept) sel <= port_sel;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            step    <= '0;
            bit_idx <= '0;
            phase   <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            step    <= step_n;
            bit_idx <= bit_n;
            phase   <= phase_n;
            done    <= fin;
        end
    end

    // S_ARM holds off until the next tick so every line step is a full tick long
    always_comb begin
        state_n = state;
        step_n  = step;
        bit_n   = bit_idx;
        phase_n = phase;
        accept  = 1'b0;
        pop     = 1'b0;
        fin     = 1'b0;
        if (abort) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start && !empty) begin
                    accept  = 1'b1;
                    state_n = S_ARM;
                end
                S_ARM: if (tick) state_n = S_PRE;
                S_PRE: if (tick) begin
                    state_n = S_SYNC;
                    step_n  = '0;
                end
                S_SYNC: if (tick) begin
                    if (step != 4'd9) begin
                        step_n = step + 1'b1;
                    end else if (empty) begin
                        state_n = S_END;
                        step_n  = '0;
                    end else begin
                        pop     = 1'b1;
                        state_n = S_DATA;
                        bit_n   = 3'd7;
                        phase_n = '0;
                    end
                end
                S_DATA: if (tick) begin
                    if (phase != 2'd2) begin
                        phase_n = phase + 1'b1;
                    end else begin
                        phase_n = '0;
                        if (bit_idx != 3'd0) begin
                            bit_n = bit_idx - 1'b1;
                        end else if (!empty) begin
                            pop   = 1'b1;
                            bit_n = 3'd7;
                        end else begin
                            state_n = S_END;
                            step_n  = '0;
                        end
                    end
                end
                S_END: if (tick) begin
                    if (step == 4'd6) begin
                        state_n = S_IDLE;
                        fin     = 1'b1;
                    end else begin
                        step_n = step + 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign busy   = (state != S_IDLE);
    assign active = (state == S_PRE) || (state == S_SYNC) || (state == S_DATA) || (state == S_END);

    // Odd bits clock on p1 with data on p5; even bits swap the roles
    always_comb begin
        line_p1  = 1'b1;
        line_p5  = 1'b1;
        clk_line = 1'b1;
        dat_line = 1'b1;
        case (state)
            S_SYNC: begin
                line_p1 = (step == 4'd9);
                line_p5 = (step == 4'd9) || !step[0];
            end
            S_DATA: begin
                clk_line = (phase != 2'd1);
                dat_line = shreg[bit_idx];
                if (bit_idx[0]) begin
                    line_p1 = clk_line;
                    line_p5 = dat_line;
                end else begin
                    line_p1 = dat_line;
                    line_p5 = clk_line;
                end
            end
            S_END: begin
                line_p5 = (step == 4'd0) || (step == 4'd6);
                line_p1 = !((step == 4'd2) || (step == 4'd4));
            end
            default: ;
        endcase
    end

    always_comb begin
        oe     = '0;
        out_p1 = '1;
        out_p5 = '1;
        hit    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            hit       = active && (sel == PSW'(i));
            oe[i]     = hit;
            out_p1[i] = hit ? line_p1 : 1'b1;
            out_p5[i] = hit ? line_p5 : 1'b1;
        end
    end
endmodule

// File: tb/tb_maple_tx_engine.sv
// Directed bench for maple_tx_engine: frame waveforms, FIFO limits, abort and reset.
module tb_maple_tx_engine;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] clk_div;
    logic [1:0] port_sel;
    logic [7:0] wr_data;
    logic       wr_en, start, abort;
    logic       full, empty, overflow, busy, done;
    logic [3:0] out_p1, out_p5, oe;

    int errors = 0;
    int checks = 0;
    logic [1:0] exp_q[$];   // expected {p1,p5} per line step

    always #5 clk = ~clk;

    maple_tx_engine #(.NUM_PORTS(4), .FIFO_DEPTH(16), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .clk_div(clk_div), .port_sel(port_sel),
        .wr_data(wr_data), .wr_en(wr_en), .start(start), .abort(abort),
        .full(full), .empty(empty), .overflow(overflow), .busy(busy), .done(done),
        .out_p1(out_p1), .out_p5(out_p5), .oe(oe)
    );

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick_clk();
        wr_en   = 1'b0;
    endtask

    task automatic exp_header();
        exp_q.delete();
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b01);
        for (int k = 0; k < 8; k++) exp_q.push_back((k % 2 == 0) ? 2'b00 : 2'b01);
        exp_q.push_back(2'b11);
    endtask

    task automatic exp_byte(input logic [7:0] b);
        logic v;
        for (int k = 7; k >= 0; k--) begin
            v = b[k];
            if (k % 2 == 1) begin
                exp_q.push_back({1'b1, v});
                exp_q.push_back({1'b0, v});
                exp_q.push_back({1'b1, v});
            end else begin
                exp_q.push_back({v, 1'b1});
                exp_q.push_back({v, 1'b0});
                exp_q.push_back({v, 1'b1});
            end
        end
    endtask

    task automatic exp_trailer();
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b11);
    endtask

    // Follows one frame until a few clocks past done (or the cycle limit),
    // tallying oe-high clocks, waveform mismatches and done pulses.
    task automatic capture_frame(input int port, input int div, input int limit,
                                 input int inj_at, input logic [7:0] inj_data,
                                 output int act, output int bad, output int dones,
                                 output logic empty_at_done);
        int post;
        logic [1:0] e;
        logic [3:0] eoe, ep1, ep5;
        act = 0; bad = 0; dones = 0; post = -1; empty_at_done = 1'b0;
        for (int c = 0; c < limit && post < 4; c++) begin
            tick_clk();
            wr_en = 1'b0;
            if (oe != 4'b0) begin
                e = (act / (div + 1) < exp_q.size()) ? exp_q[act / (div + 1)] : 2'b11;
                eoe = 4'b0; ep1 = 4'hF; ep5 = 4'hF;
                eoe[port] = 1'b1; ep1[port] = e[1]; ep5[port] = e[0];
                if ({oe, out_p1, out_p5} !== {eoe, ep1, ep5}) bad++;
                if (inj_at >= 0 && act == inj_at) begin
                    wr_en   = 1'b1;
                    wr_data = inj_data;
                end
                act++;
            end
            if (done) begin
                dones++;
                if (dones == 1) empty_at_done = empty;
            end
            if (post >= 0) post++;
            else if (done) post = 0;
        end
    endtask

    task automatic test_reset();
        tick_clk();
        tick_clk();
        checks++;
        if ({empty, full, overflow, busy, done} !== 5'b10000) begin
            $display("FAIL reset_flags: got %b expected 10000", {empty, full, overflow, busy, done});
            errors++;
        end
        checks++;
        if ({oe, out_p1, out_p5} !== {4'h0, 4'hF, 4'hF}) begin
            $display("FAIL reset_lines: got %h expected 0ff", {oe, out_p1, out_p5});
            errors++;
        end
        @(negedge clk) rst = 1'b1;
        tick_clk();
        checks++;
        if ({busy, oe} !== 5'b0) begin
            $display("FAIL reset_release_idle: got %b expected 00000", {busy, oe});
            errors++;
        end
    endtask

    task automatic test_single_byte();
        int act, bad, dones;
        logic emp;
        clk_div = 8'd0;
        push_byte(8'hA5);
        exp_header(); exp_byte(8'hA5); exp_trailer();
        start = 1'b1; port_sel = 2'd2;
        tick_clk();
        start = 1'b0;
        checks++;
        if ({busy, oe} !== {1'b1, 4'b0}) begin
            $display("FAIL single_accept: got %b expected 10000", {busy, oe});
            errors++;
        end
        capture_frame(2, 0, 200, -1, 8'h00, act, bad, dones, emp);
        checks++;
        if (bad !== 0) begin $display("FAIL single_wave: got %0d bad clocks expected 0", bad); errors++; end
        checks++;
        if (act !== 42) begin $display("FAIL single_len: got %0d expected 42", act); errors++; end
        checks++;
        if (dones !== 1) begin $display("FAIL single_done: got %0d expected 1", dones); errors++; end
        checks++;
        if (emp !== 1'b1) begin $display("FAIL single_empty: got %b expected 1", emp); errors++; end
    endtask

    task automatic test_div3();
        int act, bad, dones;
        logic emp;
        clk_div = 8'd3;
        push_byte(8'h00);
        push_byte(8'hFF);
        exp_header(); exp_byte(8'h00); exp_byte(8'hFF); exp_trailer();
        start = 1'b1; port_sel = 2'd0;
        tick_clk();
        start = 1'b0;
        capture_frame(0, 3, 400, -1, 8'h00, act, bad, dones, emp);
        checks++;
        if (bad !== 0) begin $display("FAIL div3_wave: got %0d bad clocks expected 0", bad); errors++; end
        checks++;
        if (act !== 264) begin $display("FAIL div3_len: got %0d expected 264", act); errors++; end
        checks++;
        if (dones !== 1) begin $display("FAIL div3_done: got %0d expected 1", dones); errors++; end
        checks++;
        if (emp !== 1'b1) begin $display("FAIL div3_empty: got %b expected 1", emp); errors++; end
    endtask

    task automatic test_overflow();
        int act, bad, dones;
        logic emp;
        clk_div = 8'd0;
        exp_header();
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(i * 17));
            exp_byte(8'(i * 17));
        end
        exp_trailer();
        checks++;
        if ({full, overflow} !== 2'b10) begin
            $display("FAIL ovf_full16: got %b expected 10", {full, overflow});
            errors++;
        end
        push_byte(8'h5E);
        checks++;
        if ({full, overflow} !== 2'b11) begin
            $display("FAIL ovf_sticky: got %b expected 11", {full, overflow});
            errors++;
        end
        start = 1'b1; port_sel = 2'd1;
        tick_clk();
        start = 1'b0;
        checks++;
        if ({busy, overflow} !== 2'b10) begin
            $display("FAIL ovf_clear: got %b expected 10", {busy, overflow});
            errors++;
        end
        capture_frame(1, 0, 800, -1, 8'h00, act, bad, dones, emp);
        checks++;
        if (bad !== 0) begin $display("FAIL ovf_wave: got %0d bad clocks expected 0", bad); errors++; end
        checks++;
        if (act !== 402) begin $display("FAIL ovf_len: got %0d expected 402", act); errors++; end
        checks++;
        if (dones !== 1) begin $display("FAIL ovf_done: got %0d expected 1", dones); errors++; end
    endtask

    task automatic test_start_ignored();
        int act, bad, dones, seen;
        logic emp;
        clk_div = 8'd0;
        seen = 0;
        start = 1'b1; port_sel = 2'd2;
        for (int k = 0; k < 6; k++) begin
            tick_clk();
            if (busy || done || oe != 4'b0) seen++;
            start = 1'b0;
        end
        checks++;
        if (seen !== 0) begin $display("FAIL start_empty: got %0d active clocks expected 0", seen); errors++; end
        push_byte(8'h3C);
        exp_header(); exp_byte(8'h3C); exp_trailer();
        start = 1'b1; port_sel = 2'd1;
        tick_clk();
        port_sel = 2'd3;
        capture_frame(1, 0, 200, -1, 8'h00, act, bad, dones, emp);
        start = 1'b0;
        checks++;
        if (bad !== 0) begin $display("FAIL start_busy_wave: got %0d bad clocks expected 0", bad); errors++; end
        checks++;
        if ({act, dones} !== {32'd42, 32'd1}) begin
            $display("FAIL start_busy_len_done: got %0d/%0d expected 42/1", act, dones);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        int act, bad, dones;
        logic emp;
        clk_div = 8'd0;
        push_byte(8'h5A);
        exp_header(); exp_byte(8'h5A); exp_byte(8'hC3); exp_trailer();
        start = 1'b1; port_sel = 2'd3;
        tick_clk();
        start = 1'b0;
        capture_frame(3, 0, 300, 26, 8'hC3, act, bad, dones, emp);
        checks++;
        if (bad !== 0) begin $display("FAIL b2b_wave: got %0d bad clocks expected 0", bad); errors++; end
        checks++;
        if (act !== 66) begin $display("FAIL b2b_len: got %0d expected 66", act); errors++; end
        checks++;
        if (dones !== 1) begin $display("FAIL b2b_done: got %0d expected 1", dones); errors++; end
    endtask

    task automatic test_abort();
        int n, seen;
        clk_div = 8'd0;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        start = 1'b1; port_sel = 2'd0;
        tick_clk();
        start = 1'b0;
        n = 0;
        while (oe == 4'b0 && n < 20) begin tick_clk(); n++; end
        for (int k = 0; k < 47; k++) tick_clk();
        checks++;
        if ({oe[0], out_p1[0], out_p5[0]} !== 3'b110) begin
            $display("FAIL abort_position: got %b expected 110", {oe[0], out_p1[0], out_p5[0]});
            errors++;
        end
        abort = 1'b1;
        tick_clk();
        abort = 1'b0;
        checks++;
        if ({oe, busy, empty, done} !== 7'b0000010) begin
            $display("FAIL abort_release: got %b expected 0000010", {oe, busy, empty, done});
            errors++;
        end
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            tick_clk();
            if (done || busy || oe != 4'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin $display("FAIL abort_quiet: got %0d active clocks expected 0", seen); errors++; end

        push_byte(8'h44);
        start = 1'b1; abort = 1'b1;
        tick_clk();
        start = 1'b0; abort = 1'b0;
        tick_clk();
        checks++;
        if ({busy, empty, oe} !== {2'b01, 4'b0}) begin
            $display("FAIL abort_idle_flush: got %b expected 010000", {busy, empty, oe});
            errors++;
        end

        push_byte(8'h55);
        start = 1'b1; port_sel = 2'd1;
        tick_clk();
        start = 1'b0;
        n = 0;
        while (oe == 4'b0 && n < 20) begin tick_clk(); n++; end
        for (int k = 0; k < 5; k++) tick_clk();
        rst = 1'b0;
        #1;
        checks++;
        if ({oe, out_p1, out_p5, busy, done, empty, full, overflow} !==
            {4'h0, 4'hF, 4'hF, 5'b00100}) begin
            $display("FAIL reset_midframe: got %h expected %h",
                     {oe, out_p1, out_p5, busy, done, empty, full, overflow},
                     {4'h0, 4'hF, 4'hF, 5'b00100});
            errors++;
        end
        @(negedge clk) rst = 1'b1;
        tick_clk();
        checks++;
        if ({busy, oe} !== 5'b0) begin
            $display("FAIL reset_midframe_after: got %b expected 00000", {busy, oe});
            errors++;
        end
    endtask

    initial begin
        rst = 1'b1; clk_div = 8'd0; port_sel = 2'd0; wr_data = 8'h00;
        wr_en = 1'b0; start = 1'b0; abort = 1'b0;
        #2 rst = 1'b0;
        test_reset();
        test_single_byte();
        test_div3();
        test_overflow();
        test_start_ignored();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
